// File: rtl/fso_framer_gen2_pkg.sv
// Shared types, constants and helper functions for the gen2 FSO TX framer.
// Holds the frame FSM encoding, skid entry layout, CRC-32 and scrambler steps.
package fso_framer_gen2_pkg;

  localparam int          WORD_W           = 32;
  localparam int          HDR_LEN_W        = 16;
  localparam int          HDR_IDX_W        = 8;
  localparam logic [127:0] PREAMBLE_DEFAULT = {32'hEB94_BDA3, 32'hF6AA_EE24, 64'h0};
  localparam logic [31:0] CRC_POLY         = 32'h04C1_1DB7;
  localparam logic [31:0] SCR_SEED         = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_CRC
  } state_t;

  typedef struct packed {
    logic              bs;
    logic [WORD_W-1:0] data;
  } skid_entry_t;

  // CRC-32 (poly 04C11DB7), MSB-first over the 32-bit word, no reflection.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Keystream advances 32 steps of x^32+x^22+x^2+x+1 per payload word.
  function automatic logic [31:0] scr_step(input logic [31:0] s);
    logic [31:0] x;
    x = s;
    for (int i = 0; i < 32; i++) x = {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    return x;
  endfunction

endpackage

// File: rtl/fso_framer_gen2_if.sv
// Payload, configuration and line-side signals of the gen2 framer.
// Handshakes: a beat transfers on a cycle where valid & ready are both 1; a source holds data stable while valid & !ready.
interface fso_framer_gen2_if;
  import fso_framer_gen2_pkg::*;

  logic [31:0] i_payload_data;
  logic        i_payload_valid;
  logic        i_payload_block_start;
  logic        o_payload_ready;
  logic [15:0] i_cfg_payload_len;
  logic        i_scrambler_en;
  logic        i_tx_ready;
  logic [31:0] o_tx_data;
  logic        o_tx_valid;
  logic        o_tx_sof;
  logic        o_tx_eof;
  logic [15:0] o_block_id;
  logic [15:0] o_frame_in_block;
  logic [15:0] o_frame_index;
  logic        o_underrun;
  logic        o_cfg_err;
  logic        o_align_err;
  state_t      dbg_state;

  modport master (
    output i_payload_data, i_payload_valid, i_payload_block_start,
           i_cfg_payload_len, i_scrambler_en, i_tx_ready,
    input  o_payload_ready, o_tx_data, o_tx_valid, o_tx_sof, o_tx_eof,
           o_block_id, o_frame_in_block, o_frame_index,
           o_underrun, o_cfg_err, o_align_err, dbg_state
  );

  modport slave (
    input  i_payload_data, i_payload_valid, i_payload_block_start,
           i_cfg_payload_len, i_scrambler_en, i_tx_ready,
    output o_payload_ready, o_tx_data, o_tx_valid, o_tx_sof, o_tx_eof,
           o_block_id, o_frame_in_block, o_frame_index,
           o_underrun, o_cfg_err, o_align_err, dbg_state
  );
endinterface

// File: rtl/fso_framer_gen2_skid_buf.sv
// Two-entry skid buffer: head is presented combinationally, ready is held low during reset.
module fso_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         pop
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic         push;
  logic         do_pop;

  assign in_ready  = !rst && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign do_pop    = pop && out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_data;
          else                 tail_q <= in_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the occupancy; the new word lands behind what remains.
          if (count_q == 2'd1) begin
            head_q <= in_data;
          end else begin
            head_q <= tail_q;
            tail_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fso_framer_gen2.sv
// Gen2 FSO TX framer: PREAMBLE | HDR0 | HDR1 | PAYLOAD[len] | CRC32 per frame,
// with a 2-entry input skid, underrun padding and block/frame alignment tracking.
module fso_framer_gen2
  import fso_framer_gen2_pkg::*;
#(
  parameter int           PAYLOAD_MAX      = 16,
  parameter int           PREAMBLE_WORDS   = 2,
  parameter logic [127:0] PREAMBLE         = PREAMBLE_DEFAULT,
  parameter int           FRAMES_PER_BLOCK = 255,
  parameter int           PAD_TIMEOUT      = 8,
  parameter logic [31:0]  PAD_WORD         = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  fso_framer_gen2_if.slave bus
);

  localparam logic [15:0] PAY_MAX16 = 16'(PAYLOAD_MAX);
  localparam logic [1:0]  PRE_LAST  = 2'(PREAMBLE_WORDS - 1);
  localparam logic [15:0] FIB_LAST  = 16'(FRAMES_PER_BLOCK - 1);
  localparam bit          PAD_EN    = (PAD_TIMEOUT > 0);
  localparam logic [15:0] PAD_LAST  = 16'(PAD_EN ? PAD_TIMEOUT - 1 : 0);

  state_t       state_q, state_d;
  skid_entry_t  head;
  logic         skid_valid, skid_ready, skid_pop;
  logic [1:0]   pre_cnt_q;
  logic [15:0]  len_q, pay_cnt_q, empty_cnt_q;
  logic [15:0]  block_id_q, fib_q, frame_index_q, frame_index_out_q;
  logic         scram_q, blk_seeded_q, pad_q;
  logic [31:0]  crc_q, scr_q;
  logic         underrun_q, cfg_err_q, align_err_q;
  logic         tx_valid, tx_sof, tx_eof, fire;
  logic [31:0]  tx_data, pay_word;
  logic [127:0] pre_sh;

  fso_skid_buf #(.W($bits(skid_entry_t))) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({bus.i_payload_block_start, bus.i_payload_data}),
    .in_valid  (bus.i_payload_valid),
    .in_ready  (skid_ready),
    .out_data  (head),
    .out_valid (skid_valid),
    .pop       (skid_pop)
  );

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    pay_word = pad_q ? PAD_WORD : head.data;
    pre_sh   = PREAMBLE << {pre_cnt_q, 5'd0};
    case (state_q)
      ST_PRE: begin
        tx_valid = 1'b1;
        tx_data  = pre_sh[127:96];
        tx_sof   = (pre_cnt_q == 2'd0);
      end
      ST_HDR0: begin
        tx_valid = 1'b1;
        tx_data  = {block_id_q, fib_q};
      end
      ST_HDR1: begin
        tx_valid = 1'b1;
        tx_data  = {len_q[HDR_LEN_W-1:0], 7'b0, scram_q, frame_index_q[HDR_IDX_W-1:0]};
      end
      ST_PAYLOAD: begin
        tx_valid = skid_valid || pad_q;
        tx_data  = scram_q ? (pay_word ^ scr_q) : pay_word;
      end
      ST_CRC: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q;
        tx_eof   = 1'b1;
      end
      default: ;
    endcase
    fire     = tx_valid && bus.i_tx_ready;
    skid_pop = fire && (state_q == ST_PAYLOAD) && !pad_q;
    case (state_q)
      ST_IDLE:    if (skid_valid) state_d = ST_PRE;
      ST_PRE:     if (fire && pre_cnt_q == PRE_LAST) state_d = ST_HDR0;
      ST_HDR0:    if (fire) state_d = ST_HDR1;
      ST_HDR1:    if (fire) state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (fire && pay_cnt_q == len_q - 16'd1) state_d = ST_CRC;
      ST_CRC:     if (fire) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      pre_cnt_q         <= '0;
      len_q             <= '0;
      pay_cnt_q         <= '0;
      empty_cnt_q       <= '0;
      block_id_q        <= '0;
      fib_q             <= '0;
      frame_index_q     <= '0;
      frame_index_out_q <= '0;
      scram_q           <= 1'b0;
      blk_seeded_q      <= 1'b0;
      pad_q             <= 1'b0;
      crc_q             <= '0;
      scr_q             <= '0;
      underrun_q        <= 1'b0;
      cfg_err_q         <= 1'b0;
      align_err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      underrun_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      align_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (skid_valid) begin
          if (bus.i_cfg_payload_len == 16'd0 || bus.i_cfg_payload_len > PAY_MAX16) begin
            len_q     <= PAY_MAX16;
            cfg_err_q <= 1'b1;
          end else begin
            len_q <= bus.i_cfg_payload_len;
          end
          scram_q   <= bus.i_scrambler_en;
          pre_cnt_q <= '0;
          // The first block_start after reset defines block 0; later ones advance it.
          if (head.bs) begin
            fib_q <= '0;
            if (blk_seeded_q) begin
              block_id_q <= block_id_q + 16'd1;
            end else begin
              block_id_q   <= '0;
              blk_seeded_q <= 1'b1;
            end
          end
        end
        ST_PRE: if (fire) pre_cnt_q <= pre_cnt_q + 2'd1;
        ST_HDR1: if (fire) begin
          crc_q             <= '1;
          scr_q             <= SCR_SEED;
          frame_index_out_q <= frame_index_q;
          pay_cnt_q         <= '0;
          empty_cnt_q       <= '0;
          pad_q             <= 1'b0;
        end
        ST_PAYLOAD: begin
          if (fire) begin
            crc_q     <= crc32_word(crc_q, pay_word);
            pay_cnt_q <= pay_cnt_q + 16'd1;
            if (scram_q) scr_q <= scr_step(scr_q);
            if (!pad_q && head.bs && pay_cnt_q != 16'd0) align_err_q <= 1'b1;
          end
          if (PAD_EN && !pad_q && !skid_valid) begin
            if (empty_cnt_q == PAD_LAST) begin
              pad_q      <= 1'b1;
              underrun_q <= 1'b1;
            end
            empty_cnt_q <= empty_cnt_q + 16'd1;
          end else begin
            empty_cnt_q <= '0;
          end
        end
        ST_CRC: if (fire) begin
          frame_index_q <= frame_index_q + 16'd1;
          fib_q         <= (fib_q == FIB_LAST) ? 16'd0 : fib_q + 16'd1;
          pad_q         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_payload_ready  = skid_ready;
  assign bus.o_tx_data        = tx_data;
  assign bus.o_tx_valid       = tx_valid;
  assign bus.o_tx_sof         = tx_sof;
  assign bus.o_tx_eof         = tx_eof;
  assign bus.o_block_id       = block_id_q;
  assign bus.o_frame_in_block = fib_q;
  assign bus.o_frame_index    = frame_index_out_q;
  assign bus.o_underrun       = underrun_q;
  assign bus.o_cfg_err        = cfg_err_q;
  assign bus.o_align_err      = align_err_q;
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_fso_framer_gen2.sv
// Directed bench for fso_framer_gen2: builds expected line words per frame and compares every beat.
module tb_fso_framer_gen2;
  import fso_framer_gen2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fso_framer_gen2_if bus ();
  fso_framer_gen2 dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- drivers ----------------
  logic [32:0] src_q[$];
  bit src_rand = 0;
  bit tx_rand  = 0;
  bit pushed   = 0;

  initial begin
    bus.i_payload_valid       = 1'b0;
    bus.i_payload_data        = '0;
    bus.i_payload_block_start = 1'b0;
    forever begin
      @(negedge clk);
      if (pushed && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && (!src_rand || $urandom_range(0, 1) == 1)) begin
        bus.i_payload_valid = 1'b1;
        {bus.i_payload_block_start, bus.i_payload_data} = src_q[0];
      end else begin
        bus.i_payload_valid = 1'b0;
      end
      #1 pushed = bus.i_payload_valid && bus.o_payload_ready;
    end
  end

  initial begin
    bus.i_tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.i_tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  logic [33:0] mon_q[$];
  int          mon_cyc[$];
  int          cyc = 0;
  int          n_underrun = 0, n_cfg_err = 0, n_align_err = 0, underrun_cyc = 0;
  bit          prev_stall = 0;
  logic [33:0] prev_word;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check_eq("stable", {bus.o_tx_valid, bus.o_tx_sof, bus.o_tx_eof, bus.o_tx_data}, {1'b1, prev_word});
        if (bus.o_tx_valid && bus.i_tx_ready) begin
          mon_q.push_back({bus.o_tx_sof, bus.o_tx_eof, bus.o_tx_data});
          mon_cyc.push_back(cyc);
        end
        if (bus.o_underrun) begin
          n_underrun++;
          underrun_cyc = cyc;
        end
        if (bus.o_cfg_err) n_cfg_err++;
        if (bus.o_align_err) n_align_err++;
        prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
        prev_word  = {bus.o_tx_sof, bus.o_tx_eof, bus.o_tx_data};
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [31:0] pay_q[$];

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int b = 3; b >= 0; b--) begin
      r = r ^ {w[8*b +: 8], 24'h0};
      for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] scr_next(input logic [31:0] s);
    logic [31:0] x;
    x = s;
    for (int i = 0; i < 32; i++) x = {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    return x;
  endfunction

  task automatic build_frame(input logic [31:0] hdr0, input logic [31:0] hdr1, input bit scram);
    logic [31:0] crc, ks;
    exp_q.delete();
    exp_q.push_back({2'b10, 32'hEB94_BDA3});
    exp_q.push_back({2'b00, 32'hF6AA_EE24});
    exp_q.push_back({2'b00, hdr0});
    exp_q.push_back({2'b00, hdr1});
    crc = 32'hFFFF_FFFF;
    ks  = 32'hFFFF_FFFF;
    foreach (pay_q[i]) begin
      exp_q.push_back({2'b00, scram ? (pay_q[i] ^ ks) : pay_q[i]});
      crc = crc_upd(crc, pay_q[i]);
      ks  = scr_next(ks);
    end
    exp_q.push_back({2'b01, ~crc});
  endtask

  task automatic push_src(input int count, input int bs_idx);
    for (int i = 0; i < count; i++) src_q.push_back({(i == bs_idx), pay_q[i]});
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int t = 0;
    while (mon_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, ".beats"}, 64'(mon_q.size()), 64'(n));
  endtask

  task automatic run_frame(input string tag, input int budget);
    wait_beats(tag, exp_q.size(), budget);
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s.w%0d", tag, i), (i < mon_q.size()) ? mon_q[i] : 34'bx, exp_q[i]);
  endtask

  task automatic clear_mon();
    mon_q.delete();
    mon_cyc.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.i_cfg_payload_len = 16'd16;
    bus.i_scrambler_en    = 1'b0;

    // reset state
    @(negedge clk);
    #3;
    check_eq("rst.ready", bus.o_payload_ready, 1'b0);
    check_eq("rst.valid", bus.o_tx_valid, 1'b0);
    check_eq("rst.data", bus.o_tx_data, 32'h0);
    check_eq("rst.block_id", bus.o_block_id, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check_eq("rst.ready_after", bus.o_payload_ready, 1'b1);

    // frame 0: 16 words 0..15, block start on word 0
    pay_q.delete();
    for (int i = 0; i < 16; i++) pay_q.push_back(32'(i));
    build_frame(32'h0000_0000, 32'h0010_0000, 1'b0);
    push_src(16, 0);
    run_frame("f0", 200);
    check_eq("f0.frame_index", bus.o_frame_index, 16'h0);
    check_eq("f0.fib_after", bus.o_frame_in_block, 16'h1);
    clear_mon();

    // frame 1: random backpressure and random source gaps
    src_rand = 1;
    tx_rand  = 1;
    pay_q.delete();
    for (int i = 0; i < 16; i++) pay_q.push_back($urandom);
    build_frame(32'h0000_0001, 32'h0010_0001, 1'b0);
    push_src(16, -1);
    run_frame("f1_rand", 800);
    clear_mon();
    src_rand = 0;
    tx_rand  = 0;
    @(negedge clk);

    // frame 2: len 0 clamps to 16; frame 3: len 4
    bus.i_cfg_payload_len = 16'd0;
    pay_q.delete();
    for (int i = 0; i < 16; i++) pay_q.push_back(32'h100 + 32'(i));
    build_frame(32'h0000_0002, 32'h0010_0002, 1'b0);
    push_src(16, -1);
    run_frame("f2_len0", 200);
    check_eq("f2.cfg_err_pulses", 64'(n_cfg_err), 64'd1);
    clear_mon();
    bus.i_cfg_payload_len = 16'd4;
    pay_q.delete();
    for (int i = 0; i < 4; i++) pay_q.push_back(32'h200 + 32'(i));
    build_frame(32'h0000_0003, 32'h0004_0003, 1'b0);
    push_src(4, -1);
    run_frame("f3_len4", 100);
    check_eq("f3.cfg_err_pulses", 64'(n_cfg_err), 64'd1);
    clear_mon();

    // frame 4: source stops after word 5 -> padding
    bus.i_cfg_payload_len = 16'd16;
    pay_q.delete();
    for (int i = 0; i < 16; i++) pay_q.push_back(i < 6 ? 32'hA0 + 32'(i) : 32'h0);
    build_frame(32'h0000_0004, 32'h0010_0004, 1'b0);
    push_src(6, -1);
    run_frame("f4_pad", 300);
    check_eq("f4.underrun_pulses", 64'(n_underrun), 64'd1);
    check_eq("f4.underrun_gap", 64'(underrun_cyc - ((mon_cyc.size() > 9) ? mon_cyc[9] : 0)), 64'd9);
    clear_mon();

    // frame 5: scrambled, len 2
    bus.i_cfg_payload_len = 16'd2;
    bus.i_scrambler_en    = 1'b1;
    pay_q.delete();
    pay_q.push_back(32'h1234_5678);
    pay_q.push_back(32'hCAFE_F00D);
    build_frame(32'h0000_0005, 32'h0002_0105, 1'b1);
    push_src(2, -1);
    run_frame("f5_scr", 100);
    clear_mon();
    bus.i_scrambler_en = 1'b0;

    // frame 6: block start on word 3 is an alignment error and is ignored
    bus.i_cfg_payload_len = 16'd4;
    pay_q.delete();
    for (int i = 0; i < 4; i++) pay_q.push_back(32'h300 + 32'(i));
    build_frame(32'h0000_0006, 32'h0004_0006, 1'b0);
    push_src(4, 3);
    run_frame("f6_align", 100);
    check_eq("f6.align_pulses", 64'(n_align_err), 64'd1);
    check_eq("f6.block_id", bus.o_block_id, 16'h0);
    clear_mon();

    // frames 7..254: walk frame_in_block up to its last value
    bus.i_cfg_payload_len = 16'd1;
    for (int f = 7; f < 255; f++) begin
      pay_q.delete();
      pay_q.push_back(32'hF000_0000 + 32'(f));
      build_frame({16'h0, 16'(f)}, {16'h0001, 8'h00, 8'(f)}, 1'b0);
      push_src(1, -1);
      run_frame($sformatf("f%0d", f), 60);
      clear_mon();
    end

    // frame 255: second block start -> block 1, frame_in_block 0
    pay_q.delete();
    pay_q.push_back(32'h0BAD_F00D);
    build_frame(32'h0001_0000, 32'h0001_00FF, 1'b0);
    push_src(1, 0);
    run_frame("f255_blk", 60);
    check_eq("f255.block_id", bus.o_block_id, 16'h1);
    check_eq("f255.fib_after", bus.o_frame_in_block, 16'h1);
    check_eq("f255.frame_index", bus.o_frame_index, 16'h00FF);
    check_eq("f255.align_pulses", 64'(n_align_err), 64'd1);
    clear_mon();

    // reset mid-PAYLOAD, then a fresh frame
    bus.i_cfg_payload_len = 16'd16;
    pay_q.delete();
    for (int i = 0; i < 16; i++) pay_q.push_back(32'h800 + 32'(i));
    push_src(16, -1);
    wait_beats("rst_mid.pre", 6, 100);
    @(negedge clk);
    rst = 1'b1;
    src_q.delete();
    #3;
    check_eq("rst_mid.ready", bus.o_payload_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check_eq("rst_mid.valid", bus.o_tx_valid, 1'b0);
    check_eq("rst_mid.data", bus.o_tx_data, 32'h0);
    check_eq("rst_mid.block_id", bus.o_block_id, 16'h0);
    check_eq("rst_mid.fib", bus.o_frame_in_block, 16'h0);
    check_eq("rst_mid.frame_index", bus.o_frame_index, 16'h0);
    check_eq("rst_mid.ready_after", bus.o_payload_ready, 1'b1);
    clear_mon();
    bus.i_cfg_payload_len = 16'd2;
    pay_q.delete();
    pay_q.push_back(32'h5555_AAAA);
    pay_q.push_back(32'h0F0F_F0F0);
    build_frame(32'h0000_0000, 32'h0002_0000, 1'b0);
    push_src(2, 0);
    run_frame("f_after_rst", 100);
    check_eq("after_rst.frame_index", bus.o_frame_index, 16'h0);
    check_eq("after_rst.block_id", bus.o_block_id, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
